neuron_mac_serial: RTL and testbench

Serial multiply-accumulate neuron stage that directly feeds the activation LUT/interpolator block. It consumes a stream of N_INPUTS (x, w) pairs in Q4.4 signed fixed point, adds a Q4.4 bias, and produces the 8-bit signed Q4.4 pre-activation z_value. The activation block indexes its LUT with z_value[7:4] and interpolates with z_value[3:0]. One instance exists per neuron per layer, for example 2 inputs for the XOR network.

---
 rtl/neuron_mac_serial.sv | 91 +++++++++
 tb/tb_neuron_mac_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/neuron_mac_serial.sv
// Serial Q4.4 MAC neuron: accumulates N_INPUTS x*w beats plus bias, emits saturated z_value.
// Latency: out_valid rises the cycle after the last beat; in_ready drops while a result waits on out_ready.
module neuron_mac_serial #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = 8,
   parameter int FRAC_W   = 4,
   parameter int ACC_W    = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x_data,
   input  logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] z_value,
   output logic              sat
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] ZMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ZMIN = ~ZMAX;

   typedef enum logic {ACC, DONE} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    full;
   logic                       clip_hi;
   logic                       clip_lo;
   logic [DATA_W-1:0]          z_next;

   assign prod     = $signed(x_data) * $signed(w_data);
   assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
   // Bias is aligned to the Q8.8 product scale before it seeds the sum.
   assign bias_ext = {{(ACC_W - DATA_W - FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
   assign acc_next = ((cnt == '0) ? bias_ext : acc) + prod_ext;
   assign full     = acc_next >>> FRAC_W;
   assign clip_hi  = (full > ZMAX);
   assign clip_lo  = (full < ZMIN);
   assign z_next   = clip_hi ? ZMAX[DATA_W-1:0] :
                     clip_lo ? ZMIN[DATA_W-1:0] : full[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         z_value   <= '0;
         sat       <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  acc <= acc_next;
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     z_value   <= z_next;
                     sat       <= clip_hi | clip_lo;
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= ACC;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Directed and randomized bench for neuron_mac_serial (N_INPUTS=2) against an integer reference model.
module tb_neuron_mac_serial;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x_data;
   logic [7:0] w_data;
   logic [7:0] bias;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] z_value;
   logic       sat;

   int checks = 0;
   int errors = 0;

   neuron_mac_serial #(.N_INPUTS(2), .DATA_W(8), .FRAC_W(4), .ACC_W(20)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_data(x_data), .w_data(w_data), .bias(bias),
      .out_valid(out_valid), .out_ready(out_ready),
      .z_value(z_value), .sat(sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: real-valued sum in 1/256 units, floored to 1/16, then clipped to 8-bit signed.
   function automatic logic [8:0] ref_z(input logic [7:0] b, input logic [7:0] x0, input logic [7:0] w0,
                                        input logic [7:0] x1, input logic [7:0] w1);
      int total, full, clamped;
      total = int'($signed(b)) * 16 + int'($signed(x0)) * int'($signed(w0))
            + int'($signed(x1)) * int'($signed(w1));
      if (total >= 0) full = total / 16;
      else            full = -((-total + 15) / 16);
      clamped = (full > 127) ? 127 : (full < -128) ? -128 : full;
      return {(clamped != full), 8'(clamped)};
   endfunction

   // Called on a negedge; returns on the negedge after the beat was accepted.
   task automatic beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b, input string tag);
      int t = 0;
      in_valid = 1'b1; x_data = x; w_data = w; bias = b;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_seq(input logic [7:0] x0, input logic [7:0] w0, input logic [7:0] x1,
                          input logic [7:0] w1, input logic [7:0] b0, input logic [7:0] b1,
                          input int gap, input int stall, input string tag);
      logic [8:0] e;
      e = ref_z(b0, x0, w0, x1, w1);
      beat(x0, w0, b0, tag);
      repeat (gap) @(negedge clk);
      chk({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
      out_ready = (stall == 0);
      beat(x1, w1, b1, tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_z"}, 32'(z_value), 32'(e[7:0]));
      chk({tag, "_sat"}, 32'(sat), 32'(e[8]));
      if (stall > 0) begin
         in_valid = 1'b1; x_data = 8'($urandom); w_data = 8'($urandom); bias = 8'($urandom);
         repeat (stall) begin
            @(negedge clk);
            chk({tag, "_stall_z"}, 32'(z_value), 32'(e[7:0]));
            chk({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
         chk({tag, "_release_ready"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; x_data = '0; w_data = '0; bias = '0; out_ready = 1'b1;
      #12;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_z", 32'(z_value), 32'd0);
      chk("reset_sat", 32'(sat), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      run_seq(8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'hF0, 0, 0, "basic");
      run_seq(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 0, 0, "pos_sat");
      run_seq(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h80, 0, 0, "neg_sat");
      run_seq(8'h01, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00, 0, 0, "floor");
      run_seq(8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 0, 5, "stall");
      run_seq(8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'hF0, 3, 0, "gap");
      run_seq(8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'h70, 0, 0, "bias_late");
      run_seq(8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 0, 0, "b2b_a");
      run_seq(8'hF0, 8'h10, 8'h08, 8'h10, 8'h00, 8'h00, 0, 0, "b2b_b");

      // Asynchronous reset in the middle of a sequence with a nonzero result still held.
      run_seq(8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 0, 0, "pre_rst");
      beat(8'h7F, 8'h7F, 8'h7F, "mid_rst");
      #2 rst = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid), 32'd0);
      chk("rst_async_z", 32'(z_value), 32'd0);
      chk("rst_async_sat", 32'(sat), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_seq(8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'hF0, 0, 0, "after_rst");

      for (int i = 0; i < 40; i++) begin
         run_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1) == 1 ? $urandom_range(1, 4) : 0),
                 $sformatf("rand%0d", i));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
